wor_req_poller: RTL and testbench

Downstream consumer of a wired-OR (wor) shared request line. N requesters each drive one wor net, so the line is the logical OR of all their requests. This block synchronises that line and identifies the requester by round-robin polling of per-source pending flags. It hands the identified source ID to a downstream consumer over a valid/ready handshake, acknowledges the source, and supervises the source's clearing of its pending flag with a timeout.

---
 rtl/wor_req_poller_if.sv | 25 ++
 rtl/wor_req_poller.sv | 113 +++++++++++
 tb/tb_wor_req_poller.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wor_req_poller_if.sv
// Bundle of request, pending, event handshake and status signals between the
// wired-OR request poller (master) and its sources/consumer (slave).
interface wor_req_poller_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic           wor_req;
  logic [N-1:0]   src_pend;
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic           evt_ready;
  logic [N-1:0]   src_ack;
  logic           spurious;
  logic           timeout_err;

  modport master (
    input  wor_req, src_pend, evt_ready,
    output evt_valid, evt_id, src_ack, spurious, timeout_err
  );

  modport slave (
    output wor_req, src_pend, evt_ready,
    input  evt_valid, evt_id, src_ack, spurious, timeout_err
  );
endinterface

// File: rtl/wor_req_poller.sv
// Services a shared wired-OR request line: synchronises it, finds the requester
// by round-robin polling of src_pend, reports its ID, acks it and supervises the clear.
module wor_req_poller #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst,
  wor_req_poller_if.master    bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SCAN   = 3'd1;
  localparam logic [2:0] S_REPORT = 3'd2;
  localparam logic [2:0] S_ACK    = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;

  logic [2:0]     r_state;
  logic           r_sync1;
  logic           r_sync2;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_last_id;
  logic [IDW-1:0] r_scan_cnt;
  logic [IDW-1:0] r_evt_id;
  logic [7:0]     r_tmo_cnt;
  logic           r_spur;
  logic           r_tmo_err;
  logic [8:0]     w_tmo_next;

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    if (id == IDW'(N - 1)) return '0;
    else                   return id + 1'b1;
  endfunction

  // wor_req is asynchronous to clk: two-flop synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.wor_req;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tmo_next = {1'b0, r_tmo_cnt} + 9'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_last_id  <= IDW'(N - 1);
      r_scan_cnt <= '0;
      r_evt_id   <= '0;
      r_tmo_cnt  <= '0;
      r_spur     <= 1'b0;
      r_tmo_err  <= 1'b0;
    end else begin
      r_spur    <= 1'b0;
      r_tmo_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_sync2) begin
            r_ptr      <= next_id(r_last_id);
            r_scan_cnt <= '0;
            r_state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (bus.src_pend[r_ptr]) begin
            r_evt_id <= r_ptr;
            r_state  <= S_REPORT;
          end else if (r_scan_cnt == IDW'(N - 1)) begin
            r_spur  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_ptr      <= next_id(r_ptr);
            r_scan_cnt <= r_scan_cnt + 1'b1;
          end
        end
        S_REPORT: begin
          if (bus.evt_ready) r_state <= S_ACK;
        end
        S_ACK: begin
          // Advance the round-robin origin even if this source later times out
          r_last_id <= r_evt_id;
          r_tmo_cnt <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (!bus.src_pend[r_evt_id]) begin
            r_state <= S_IDLE;
          end else if (w_tmo_next == 9'(TIMEOUT)) begin
            r_tmo_err <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_tmo_cnt <= w_tmo_next[7:0];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from registered state only, so reset clears them at once
  assign bus.evt_valid   = (r_state == S_REPORT);
  assign bus.evt_id      = r_evt_id;
  assign bus.src_ack     = (r_state == S_ACK) ? (N'(1) << r_evt_id) : '0;
  assign bus.spurious    = r_spur;
  assign bus.timeout_err = r_tmo_err;

endmodule

// File: tb/tb_wor_req_poller.sv
// Directed testbench for wor_req_poller: reset, single request, round-robin,
// backpressure, reset during REPORT, spurious scan and timeout with wrap.
module tb_wor_req_poller;
  localparam int N       = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [N-1:0] pend;
  logic [N-1:0] reqd;
  logic         force_req;
  int           auto_dly;
  int           cd[N];

  wor_req_poller_if #(.N(N), .IDW(IDW)) bus();

  wor_req_poller #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // A source stops requesting on its ack; its pend bit clears auto_dly samples later
  task automatic drive();
    bus.src_pend = pend;
    bus.wor_req  = (|(pend & reqd)) | force_req;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (cd[i] > 0) begin
        cd[i] = cd[i] - 1;
        if (cd[i] == 0) pend[i] = 1'b0;
      end
      if (bus.src_ack[i] === 1'b1) begin
        reqd[i] = 1'b0;
        if (auto_dly > 0) cd[i] = auto_dly;
      end
    end
    drive();
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    while (bus.evt_valid !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    pend = '0; reqd = '0; force_req = 1'b0; auto_dly = 0;
    for (int i = 0; i < N; i++) cd[i] = 0;
    bus.evt_ready = 1'b0;
    drive();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.evt_valid, bus.src_ack, bus.spurious, bus.timeout_err, bus.evt_id} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b ack=%b sp=%b to=%b id=%0d required all 0",
               bus.evt_valid, bus.src_ack, bus.spurious, bus.timeout_err, bus.evt_id);
    end
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.evt_valid, bus.src_ack, bus.spurious, bus.timeout_err} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got v=%b ack=%b sp=%b to=%b required all 0",
               bus.evt_valid, bus.src_ack, bus.spurious, bus.timeout_err);
    end
  endtask

  task automatic test_round_robin();
    logic [IDW-1:0] ids[4];
    logic [N-1:0]   acks[4];
    logic [N-1:0]   exp_ack;
    int nid = 0;
    int nack = 0;
    bus.evt_ready = 1'b1;
    pend = 4'b1111; reqd = 4'b1111; auto_dly = 1;
    drive();
    for (int t = 0; t < 80 && nack < 4; t++) begin
      tick();
      if (bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1 && nid < 4) begin
        ids[nid] = bus.evt_id;
        nid++;
      end
      if (bus.src_ack !== '0) begin
        if (nack < 4) acks[nack] = bus.src_ack;
        nack++;
        checks++;
        if (bus.evt_valid !== 1'b0) begin
          errors++;
          $display("FAIL rr_ack_valid_overlap: got evt_valid=%b required 0", bus.evt_valid);
        end
      end
    end
    checks++;
    if (nid != 4 || nack != 4) begin
      errors++;
      $display("FAIL rr_counts: got events=%0d acks=%0d required 4 and 4", nid, nack);
    end
    for (int k = 0; k < 4; k++) begin
      if (k < nid) begin
        checks++;
        if (ids[k] !== IDW'(k)) begin
          errors++;
          $display("FAIL rr_id%0d: got %0d required %0d", k, ids[k], k);
        end
      end
      if (k < nack) begin
        exp_ack = N'(1) << k;
        checks++;
        if (acks[k] !== exp_ack) begin
          errors++;
          $display("FAIL rr_ack%0d: got %b required %b", k, acks[k], exp_ack);
        end
      end
    end
    repeat (6) tick();
  endtask

  task automatic test_single();
    int n;
    int bad = 0;
    pend = 4'b0100; reqd = 4'b0100; auto_dly = 2; bus.evt_ready = 1'b1;
    drive();
    wait_valid(20, n);
    checks++;
    if (n != 6 || bus.evt_id !== 2'd2) begin
      errors++;
      $display("FAIL single_report: got latency=%0d id=%0d required 6 and 2", n, bus.evt_id);
    end
    tick();
    checks++;
    if (bus.src_ack !== 4'b0100 || bus.evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_ack: got ack=%b v=%b required 0100 and 0", bus.src_ack, bus.evt_valid);
    end
    tick();
    checks++;
    if (bus.src_ack !== 4'b0000) begin
      errors++;
      $display("FAIL single_ack_width: got %b required 0000", bus.src_ack);
    end
    for (int t = 0; t < 8; t++) begin
      tick();
      if (bus.evt_valid !== 1'b0 || bus.spurious !== 1'b0 || bus.timeout_err !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_quiet: got %0d active cycles required 0", bad);
    end
  endtask

  task automatic test_backpressure();
    int n;
    pend = 4'b0001; reqd = 4'b0001; auto_dly = 1; bus.evt_ready = 1'b0;
    drive();
    wait_valid(20, n);
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL bp_latency: got %0d required 5", n);
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      checks++;
      if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd0 || bus.src_ack !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b id=%0d ack=%b required 1, 0, 0000",
                 k, bus.evt_valid, bus.evt_id, bus.src_ack);
      end
    end
    bus.evt_ready = 1'b1;
    tick();
    checks++;
    if (bus.src_ack !== 4'b0001 || bus.evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_ack: got ack=%b v=%b required 0001 and 0", bus.src_ack, bus.evt_valid);
    end
    tick();
    checks++;
    if (bus.src_ack !== 4'b0000) begin
      errors++;
      $display("FAIL bp_ack_width: got %b required 0000", bus.src_ack);
    end
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    int n;
    int bad = 0;
    pend = 4'b0011; reqd = 4'b0011; auto_dly = 0; bus.evt_ready = 1'b0;
    drive();
    wait_valid(20, n);
    checks++;
    if (n != 4 || bus.evt_id !== 2'd1) begin
      errors++;
      $display("FAIL mid_pre_report: got latency=%0d id=%0d required 4 and 1", n, bus.evt_id);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.evt_valid, bus.src_ack, bus.spurious, bus.timeout_err} !== '0) begin
      errors++;
      $display("FAIL mid_reset_async: got v=%b ack=%b sp=%b to=%b required all 0",
               bus.evt_valid, bus.src_ack, bus.spurious, bus.timeout_err);
    end
    tick();
    checks++;
    if ({bus.evt_valid, bus.src_ack} !== '0) begin
      errors++;
      $display("FAIL mid_reset_held: got v=%b ack=%b required 0", bus.evt_valid, bus.src_ack);
    end
    rst = 1'b0;
    bus.evt_ready = 1'b1;
    wait_valid(20, n);
    checks++;
    if (n != 4 || bus.evt_id !== 2'd0) begin
      errors++;
      $display("FAIL mid_first_scan: got latency=%0d id=%0d required 4 and 0", n, bus.evt_id);
    end
    tick();
    checks++;
    if (bus.src_ack !== 4'b0001) begin
      errors++;
      $display("FAIL mid_ack: got %b required 0001", bus.src_ack);
    end
    pend = '0;
    drive();
    for (int t = 0; t < 6; t++) begin
      tick();
      if (bus.evt_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_quiet: got %0d valid cycles required 0", bad);
    end
  endtask

  task automatic test_spurious();
    int cnt = 0;
    int at = 0;
    int bad = 0;
    pend = '0; reqd = '0; force_req = 1'b1; bus.evt_ready = 1'b1;
    drive();
    repeat (3) tick();
    force_req = 1'b0;
    drive();
    for (int t = 4; t <= 14; t++) begin
      tick();
      if (bus.spurious === 1'b1) begin
        cnt++;
        at = t;
      end
      if (bus.evt_valid !== 1'b0) bad++;
    end
    checks++;
    if (cnt != 1 || at != 7) begin
      errors++;
      $display("FAIL spurious_pulse: got count=%0d at=%0d required 1 at 7", cnt, at);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL spurious_no_valid: got %0d valid cycles required 0", bad);
    end
  endtask

  task automatic test_timeout();
    int n;
    int cnt = 0;
    int at = 0;
    pend = 4'b1000; reqd = 4'b1000; auto_dly = 0; bus.evt_ready = 1'b1;
    drive();
    wait_valid(20, n);
    checks++;
    if (n != 6 || bus.evt_id !== 2'd3) begin
      errors++;
      $display("FAIL tmo_report: got latency=%0d id=%0d required 6 and 3", n, bus.evt_id);
    end
    tick();
    checks++;
    if (bus.src_ack !== 4'b1000) begin
      errors++;
      $display("FAIL tmo_ack: got %b required 1000", bus.src_ack);
    end
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (bus.timeout_err === 1'b1) begin
        cnt++;
        at = t;
      end
    end
    checks++;
    if (cnt != 1 || at != TIMEOUT + 1) begin
      errors++;
      $display("FAIL tmo_pulse: got count=%0d at=%0d required 1 at %0d", cnt, at, TIMEOUT + 1);
    end
    reqd = 4'b1000;
    drive();
    wait_valid(20, n);
    checks++;
    if (n != 7 || bus.evt_id !== 2'd3) begin
      errors++;
      $display("FAIL tmo_wrap_scan: got latency=%0d id=%0d required 7 and 3", n, bus.evt_id);
    end
    tick();
    checks++;
    if (bus.src_ack !== 4'b1000) begin
      errors++;
      $display("FAIL tmo_second_ack: got %b required 1000", bus.src_ack);
    end
    pend = '0;
    drive();
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_reset_mid();
    test_spurious();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t required finished", $time);
    $fatal(1);
  end

endmodule
